// File: rtl/rf_port_arbiter.sv
// rtl/rf_port_arbiter.sv - two-requester round-robin arbiter for the register-file port (option: RF_ARB_TIMEOUT_EN)
module rf_port_arbiter #(
    parameter int Data_width     = 8,
    parameter int Address_width  = 4,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     M0_Req,
    input  logic                     M0_Wr,
    input  logic [Address_width-1:0] M0_Address,
    input  logic [Data_width-1:0]    M0_WrData,
    output logic                     M0_Ack,
    output logic [Data_width-1:0]    M0_RdData,
    output logic                     M0_RdData_valid,
    input  logic                     M1_Req,
    input  logic                     M1_Wr,
    input  logic [Address_width-1:0] M1_Address,
    input  logic [Data_width-1:0]    M1_WrData,
    output logic                     M1_Ack,
    output logic [Data_width-1:0]    M1_RdData,
    output logic                     M1_RdData_valid,
    output logic                     WrEN,
    output logic                     RdEN,
    output logic [Address_width-1:0] Address,
    output logic [Data_width-1:0]    WrData,
    input  logic [Data_width-1:0]    Rd_data,
    input  logic                     RdData_valid,
    output logic                     Busy,
    output logic                     Rd_error
);
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ISSUE   = 2'd1;
    localparam logic [1:0] ST_WAIT_RD = 2'd2;

    logic [1:0]               state_q, state_d;
    logic                     rr_q, rr_d;
    logic                     owner_q, owner_d;
    logic                     wren_q, wren_d;
    logic                     rden_q, rden_d;
    logic [Address_width-1:0] addr_q, addr_d;
    logic [Data_width-1:0]    wdata_q, wdata_d;
    logic [1:0]               ack_q, ack_d;
    logic [1:0]               rdv_q, rdv_d;
    logic [Data_width-1:0]    rdata0_q, rdata0_d;
    logic [Data_width-1:0]    rdata1_q, rdata1_d;
    logic                     busy_q, busy_d;

`ifdef RF_ARB_TIMEOUT_EN
    localparam logic [3:0] TO_LAST = 4'(TIMEOUT_CYCLES - 1);
    logic [3:0] cnt_q, cnt_d;
    logic       err_q, err_d;
`endif

    // A request still high during its own Ack cycle must not be granted again.
    logic [1:0] elig;
    logic       grant_idx;
    logic       grant_wr;
    assign elig      = {M1_Req & ~ack_q[1], M0_Req & ~ack_q[0]};
    assign grant_idx = (elig == 2'b11) ? rr_q : elig[1];
    assign grant_wr  = grant_idx ? M1_Wr : M0_Wr;

    always_comb begin
        state_d  = state_q;
        rr_d     = rr_q;
        owner_d  = owner_q;
        wren_d   = 1'b0;
        rden_d   = 1'b0;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        ack_d    = 2'b00;
        rdv_d    = 2'b00;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
`ifdef RF_ARB_TIMEOUT_EN
        cnt_d    = cnt_q;
        err_d    = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (|elig) begin
                    addr_d           = grant_idx ? M1_Address : M0_Address;
                    wdata_d          = grant_idx ? M1_WrData : M0_WrData;
                    wren_d           = grant_wr;
                    rden_d           = ~grant_wr;
                    ack_d[grant_idx] = grant_wr;
                    owner_d          = grant_idx;
                    rr_d             = ~grant_idx;
                    state_d          = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_d = wren_q ? ST_IDLE : ST_WAIT_RD;
`ifdef RF_ARB_TIMEOUT_EN
                cnt_d   = 4'd0;
`endif
            end
            ST_WAIT_RD: begin
                if (RdData_valid) begin
                    if (owner_q) rdata1_d = Rd_data;
                    else         rdata0_d = Rd_data;
                    rdv_d[owner_q] = 1'b1;
                    ack_d[owner_q] = 1'b1;
                    state_d        = ST_IDLE;
                end
`ifdef RF_ARB_TIMEOUT_EN
                else if (cnt_q == TO_LAST) begin
                    ack_d[owner_q] = 1'b1;
                    err_d          = 1'b1;
                    state_d        = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
`endif
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q  <= ST_IDLE;
            rr_q     <= 1'b0;
            owner_q  <= 1'b0;
            wren_q   <= 1'b0;
            rden_q   <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            ack_q    <= 2'b00;
            rdv_q    <= 2'b00;
            rdata0_q <= '0;
            rdata1_q <= '0;
            busy_q   <= 1'b0;
`ifdef RF_ARB_TIMEOUT_EN
            cnt_q    <= 4'd0;
            err_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            rr_q     <= rr_d;
            owner_q  <= owner_d;
            wren_q   <= wren_d;
            rden_q   <= rden_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            ack_q    <= ack_d;
            rdv_q    <= rdv_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
            busy_q   <= busy_d;
`ifdef RF_ARB_TIMEOUT_EN
            cnt_q    <= cnt_d;
            err_q    <= err_d;
`endif
        end
    end

    assign WrEN            = wren_q;
    assign RdEN            = rden_q;
    assign Address         = addr_q;
    assign WrData          = wdata_q;
    assign M0_Ack          = ack_q[0];
    assign M1_Ack          = ack_q[1];
    assign M0_RdData_valid = rdv_q[0];
    assign M1_RdData_valid = rdv_q[1];
    assign M0_RdData       = rdata0_q;
    assign M1_RdData       = rdata1_q;
    assign Busy            = busy_q;
`ifdef RF_ARB_TIMEOUT_EN
    assign Rd_error        = err_q;
`else
    assign Rd_error        = 1'b0;
`endif
endmodule

// File: tb/tb_rf_port_arbiter.sv
// tb/tb_rf_port_arbiter.sv - directed plus randomized checks of rf_port_arbiter against a transaction-level model
module tb_rf_port_arbiter;
    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       M0_Req = 0, M0_Wr = 0, M1_Req = 0, M1_Wr = 0;
    logic [3:0] M0_Address = 0, M1_Address = 0;
    logic [7:0] M0_WrData = 0, M1_WrData = 0;
    logic       M0_Ack, M0_RdData_valid, M1_Ack, M1_RdData_valid;
    logic [7:0] M0_RdData, M1_RdData;
    logic       WrEN, RdEN, Busy, Rd_error;
    logic [3:0] Address;
    logic [7:0] WrData;
    logic [7:0] Rd_data = 0;
    logic       RdData_valid = 0;

    int n_cmp  = 0;
    int n_fail = 0;

    rf_port_arbiter dut (
        .CLK(CLK), .RST(RST),
        .M0_Req(M0_Req), .M0_Wr(M0_Wr), .M0_Address(M0_Address), .M0_WrData(M0_WrData),
        .M0_Ack(M0_Ack), .M0_RdData(M0_RdData), .M0_RdData_valid(M0_RdData_valid),
        .M1_Req(M1_Req), .M1_Wr(M1_Wr), .M1_Address(M1_Address), .M1_WrData(M1_WrData),
        .M1_Ack(M1_Ack), .M1_RdData(M1_RdData), .M1_RdData_valid(M1_RdData_valid),
        .WrEN(WrEN), .RdEN(RdEN), .Address(Address), .WrData(WrData),
        .Rd_data(Rd_data), .RdData_valid(RdData_valid), .Busy(Busy), .Rd_error(Rd_error)
    );

    initial forever #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

`ifdef RF_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    // Model: who owns the port, whether its command is on the bus this cycle, and how long a read has waited.
    int         m_owner  = -1;
    bit         m_issue  = 0;
    bit         m_rd     = 0;
    int         m_waited = 0;
    int         m_rr     = 0;
    logic       e_wren = 0, e_rden = 0, e_busy = 0, e_err = 0;
    logic [3:0] e_addr = 0;
    logic [7:0] e_wdata = 0, e_rdata0 = 0, e_rdata1 = 0;
    logic [1:0] e_ack = 0, e_rdv = 0;

    task automatic model_step();
        bit         req[2], wr[2], el[2];
        logic [3:0] a[2];
        logic [7:0] d[2];
        int         g;
        req[0] = M0_Req; wr[0] = M0_Wr; a[0] = M0_Address; d[0] = M0_WrData;
        req[1] = M1_Req; wr[1] = M1_Wr; a[1] = M1_Address; d[1] = M1_WrData;
        el[0] = req[0] && !e_ack[0];
        el[1] = req[1] && !e_ack[1];
        e_wren = 0; e_rden = 0; e_ack = 0; e_rdv = 0; e_err = 0;
        if (m_owner < 0) begin
            g = -1;
            if (el[0] && el[1]) g = m_rr;
            else if (el[0])     g = 0;
            else if (el[1])     g = 1;
            if (g >= 0) begin
                e_addr = a[g]; e_wdata = d[g];
                e_wren = wr[g]; e_rden = !wr[g];
                e_ack[g] = wr[g];
                m_rr = 1 - g; m_owner = g; m_issue = 1; m_rd = !wr[g];
            end
        end else if (m_issue) begin
            m_issue = 0; m_waited = 0;
            if (!m_rd) m_owner = -1;
        end else if (RdData_valid) begin
            if (m_owner == 1) e_rdata1 = Rd_data; else e_rdata0 = Rd_data;
            e_rdv[m_owner] = 1; e_ack[m_owner] = 1; m_owner = -1;
        end else if (TO_EN && m_waited + 1 == 15) begin
            e_ack[m_owner] = 1; e_err = 1; m_owner = -1;
        end else begin
            m_waited++;
        end
        e_busy = (m_owner >= 0);
    endtask

    always @(posedge CLK or negedge RST) begin
        if (!RST) begin
            m_owner = -1; m_issue = 0; m_rd = 0; m_waited = 0; m_rr = 0;
            e_wren = 0; e_rden = 0; e_busy = 0; e_err = 0; e_addr = 0; e_wdata = 0;
            e_rdata0 = 0; e_rdata1 = 0; e_ack = 0; e_rdv = 0;
        end else begin
            model_step();
        end
    end

    logic [35:0] dut_vec, exp_vec;
    assign dut_vec = {WrEN, RdEN, Address, WrData, M0_Ack, M1_Ack, M0_RdData, M1_RdData,
                      M0_RdData_valid, M1_RdData_valid, Busy, Rd_error};
    assign exp_vec = {e_wren, e_rden, e_addr, e_wdata, e_ack[0], e_ack[1], e_rdata0, e_rdata1,
                      e_rdv[0], e_rdv[1], e_busy, e_err};

    always @(negedge CLK) chk("cycle_vs_model", dut_vec, exp_vec);

    // Register-file stand-in: 0 answers one cycle after RdEN, 1 answers randomly, 2 is driven by hand.
    int         rf_mode = 0;
    logic       rf_manual_valid = 0;
    logic       rf_pend = 0;
    logic [7:0] rf_pend_data = 0;
    logic [7:0] mem [16];
    always @(negedge CLK) begin
        case (rf_mode)
            0: begin
                RdData_valid = rf_pend; Rd_data = rf_pend_data;
                rf_pend = RdEN; rf_pend_data = mem[Address];
            end
            1: begin
                RdData_valid = ($urandom_range(0, 3) == 0); Rd_data = 8'($urandom);
            end
            default: RdData_valid = rf_manual_valid;
        endcase
        if (WrEN) mem[Address] = WrData;
    end

    task automatic next_cmd(input logic ack, input logic req_now, input logic wr_now,
                            input logic [3:0] a_now, input logic [7:0] d_now,
                            output logic req, output logic wr, output logic [3:0] a, output logic [7:0] d);
        int r;
        req = req_now; wr = wr_now; a = a_now; d = d_now;
        if (ack || !req_now) begin
            wr = 1'($urandom); a = 4'($urandom); d = 8'($urandom);
            req = ack ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 2) == 0);
        end else begin
            r = $urandom_range(0, 15);
            if (r == 0)     req = 0;
            else if (r < 3) begin wr = 1'($urandom); a = 4'($urandom); d = 8'($urandom); end
        end
    endtask

    initial begin
        foreach (mem[i]) mem[i] = 8'h00;
        #1 RST = 0;
        @(negedge CLK);
        chk("reset_outputs", dut_vec, 36'h0);
        RST = 1;

        // M0 writes 5A to address 3
        M0_Req = 1; M0_Wr = 1; M0_Address = 4'h3; M0_WrData = 8'h5A;
        @(negedge CLK);
        chk("wr_issue", {WrEN, RdEN, Address, WrData, M0_Ack, M1_Ack, Busy},
            {1'b1, 1'b0, 4'h3, 8'h5A, 1'b1, 1'b0, 1'b1});
        M0_Req = 0;
        @(negedge CLK);
        chk("wr_done", {WrEN, M0_Ack, Busy, Address, WrData}, {1'b0, 1'b0, 1'b0, 4'h3, 8'h5A});

        // M1 reads address 3
        M1_Req = 1; M1_Wr = 0; M1_Address = 4'h3;
        @(negedge CLK);
        chk("rd_issue", {RdEN, WrEN, Address, M1_Ack, Busy}, {1'b1, 1'b0, 4'h3, 1'b0, 1'b1});
        @(negedge CLK);
        chk("rd_wait", {RdEN, Busy, M1_Ack, M1_RdData_valid}, {1'b0, 1'b1, 1'b0, 1'b0});
        @(negedge CLK);
        chk("rd_resp", {M1_RdData, M1_RdData_valid, M1_Ack, M0_RdData, M0_RdData_valid, Busy},
            {8'h5A, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0});
        M1_Req = 0;
        @(negedge CLK);
        chk("rd_after", {M1_RdData, M1_RdData_valid, M1_Ack}, {8'h5A, 1'b0, 1'b0});

        // both hold write requests: strict alternation starting from M0
        M0_Req = 1; M0_Wr = 1; M0_Address = 4'h1; M0_WrData = 8'h11;
        M1_Req = 1; M1_Wr = 1; M1_Address = 4'h2; M1_WrData = 8'h22;
        for (int i = 0; i < 4; i++) begin
            logic [3:0] ea;
            logic [1:0] eack;
            ea   = (i % 2 == 1) ? 4'h2 : 4'h1;
            eack = (i % 2 == 1) ? 2'b01 : 2'b10;
            @(negedge CLK);
            chk($sformatf("rr_grant%0d", i), {WrEN, Address, M0_Ack, M1_Ack}, {1'b1, ea, eack});
            @(negedge CLK);
            chk($sformatf("rr_gap%0d", i), {WrEN, RdEN, Busy}, 3'b000);
        end
        M0_Req = 0; M1_Req = 0;

        // read request held through its own Ack cycle must not be re-issued
        M0_Req = 1; M0_Wr = 0; M0_Address = 4'h1;
        @(negedge CLK);
        chk("hold_issue", {RdEN, Address}, {1'b1, 4'h1});
        @(negedge CLK);
        @(negedge CLK);
        chk("hold_resp", {M0_RdData, M0_RdData_valid, M0_Ack, M1_RdData}, {8'h11, 1'b1, 1'b1, 8'h5A});
        @(negedge CLK);
        chk("hold_no_regrant", {RdEN, WrEN, Busy, M0_Ack}, 4'b0000);
        M0_Req = 0;
        @(negedge CLK);
        chk("hold_idle", {RdEN, Busy}, 2'b00);

`ifdef RF_ARB_TIMEOUT_EN
        rf_mode = 2; rf_manual_valid = 0;
        M0_Req = 1; M0_Wr = 0; M0_Address = 4'h4;
        @(negedge CLK);
        chk("to_issue", RdEN, 1'b1);
        for (int c = 2; c <= 16; c++) begin
            @(negedge CLK);
            chk($sformatf("to_wait%0d", c), {Rd_error, M0_Ack, Busy}, 3'b001);
        end
        @(negedge CLK);
        chk("to_fire", {Rd_error, M0_Ack, M0_RdData_valid, M0_RdData, Busy},
            {1'b1, 1'b1, 1'b0, 8'h11, 1'b0});
        M0_Req = 0;
        @(negedge CLK);
        chk("to_clear", {Rd_error, M0_Ack}, 2'b00);
`endif

        // reset while waiting for read data
        rf_mode = 2; rf_manual_valid = 0;
        M1_Req = 1; M1_Wr = 0; M1_Address = 4'h2;
        @(negedge CLK);
        chk("rst_issue", RdEN, 1'b1);
        @(negedge CLK);
        chk("rst_wait", {Busy, RdEN}, 2'b10);
        #2 RST = 0; M1_Req = 0; rf_manual_valid = 1;
        #1 chk("rst_async", dut_vec, 36'h0);
        @(negedge CLK);
        #2 RST = 1;
        @(negedge CLK);
        chk("rst_late_valid", {M1_Ack, M1_RdData_valid, Busy, M1_RdData}, {1'b0, 1'b0, 1'b0, 8'h00});
        rf_manual_valid = 0;

        // randomized traffic against the model
        rf_mode = 1;
        for (int it = 0; it < 3000; it++) begin
            @(negedge CLK);
            next_cmd(M0_Ack, M0_Req, M0_Wr, M0_Address, M0_WrData, M0_Req, M0_Wr, M0_Address, M0_WrData);
            next_cmd(M1_Ack, M1_Req, M1_Wr, M1_Address, M1_WrData, M1_Req, M1_Wr, M1_Address, M1_WrData);
            if (it == 1500) begin
                #2 RST = 0;
                #6 RST = 1;
            end
        end
        M0_Req = 0; M1_Req = 0;
        @(negedge CLK);
        @(negedge CLK);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/rf_port_arbiter.md
Name: rf_port_arbiter

Overview:
- Shares the single register-file access port (WrEN/RdEN/Address/WrData in; Rd_data/RdData_valid out) between two requesters.
- Requester 0 is the system controller; requester 1 is a secondary master (configuration/debug loader).
- Arbitration is round-robin with a request/acknowledge handshake.
- Read data is returned only to the requester that issued the read.

Parameters:
Data_width, 8, register-file data width
Address_width, 4, register-file address width
TIMEOUT_CYCLES, 15, read-response timeout limit; used only with the optional feature

Ports:
CLK  in  1  system clock
RST  in  1  asynchronous active-low reset
M0_Req  in  1  requester 0 request; held with its command until M0_Ack
M0_Wr  in  1  1 = write, 0 = read
M0_Address  in  Address_width  target address
M0_WrData  in  Data_width  write data
M0_Ack  out  1  one-cycle pulse when the transaction completes
M0_RdData  out  Data_width  read data; held until the next requester-0 read completes
M0_RdData_valid  out  1  one-cycle pulse marking M0_RdData as valid
M1_Req, M1_Wr, M1_Address, M1_WrData, M1_Ack, M1_RdData, M1_RdData_valid: identical set for requester 1
WrEN  out  1  register-file write enable
RdEN  out  1  register-file read enable
Address  out  Address_width  register-file address
WrData  out  Data_width  register-file write data
Rd_data  in  Data_width  register-file read data
RdData_valid  in  1  register-file read-data valid
Busy  out  1  high whenever the state is not IDLE
Rd_error  out  1  read-timeout pulse; tied to 0 without the optional feature

Behaviour:
- Registered outputs:
  - All outputs are registered.
  - On RST low, all outputs are 0, state = IDLE and rr_ptr = 0.
- States:
  - IDLE: waiting for a request.
  - ISSUE: command driven to the register file.
  - WAIT_RD: waiting for read data.
- Eligibility: requester k is eligible in IDLE when Mk_Req = 1 and Mk_Ack = 0 in that cycle. This prevents re-granting a request that is still high during its own Ack cycle.
- IDLE:
  - No eligible requester: stay in IDLE.
  - One eligible requester: grant it.
  - Both eligible: grant requester rr_ptr.
  - On grant, at the next edge:
    - load Address and WrData from the granted requester;
    - set WrEN = Mk_Wr and RdEN = ~Mk_Wr;
    - store the granted index;
    - set rr_ptr to the other requester;
    - go to ISSUE.
- ISSUE (exactly one cycle):
  - WrEN or RdEN is high for this single cycle and cleared at the next edge.
  - Write: Mk_Ack = 1 during ISSUE; next state IDLE.
  - Read: next state WAIT_RD.
- WAIT_RD:
  - On RdData_valid = 1, at the next edge:
    - Mk_RdData <= Rd_data;
    - Mk_RdData_valid = 1 and Mk_Ack = 1 for one cycle;
    - state returns to IDLE.
  - The other requester's RdData is unchanged.
- Latency and throughput:
  - Write: Req sampled in cycle t; WrEN high in t+1; Ack in t+1.
  - Read: RdEN high in t+1; if the register file answers in t+2, Ack/RdData_valid fire in t+3.
  - Minimum spacing is 2 cycles per write and 3 cycles per read.
- Request rules:
  - A request that drops before Ack is ignored unless it has already been granted. A granted transaction always completes.
  - Address/WrData/Wr changes after grant have no effect.
- RdData_valid arriving outside WAIT_RD is ignored.
- Address and WrData keep their last values when idle. WrEN and RdEN are never high simultaneously.
- Reset mid-operation: the transaction is dropped, no Ack is generated, and all outputs return to 0 asynchronously.

Optional Feature:
- Macro: RF_ARB_TIMEOUT_EN.
- Defined:
  - A 4-bit counter clears on entry to WAIT_RD and increments each cycle in WAIT_RD.
  - If it reaches TIMEOUT_CYCLES without RdData_valid:
    - Mk_Ack = 1 and Rd_error = 1 for one cycle;
    - Mk_RdData_valid stays 0 and Mk_RdData is unchanged;
    - state returns to IDLE.
  - If RdData_valid arrives in the same cycle the counter hits the limit, the data wins and there is no error.
- Undefined: no counter; WAIT_RD waits indefinitely; Rd_error is constant 0.

Test Plan:
- After reset, M0 writes 8'h5A to address 4'h3: WrEN = 1 with Address = 3 and WrData = 5A for one cycle, M0_Ack pulses in the same cycle, then Busy = 0.
- M1 reads address 3, with the register-file model returning 5A one cycle after RdEN: M1_RdData = 5A with M1_RdData_valid = M1_Ack = 1 for one cycle, three cycles after request sampling; M0_RdData unchanged.
- M0 and M1 both hold Req for writes to addresses 1 and 2 with rr_ptr = 0: grant order is M0, M1, M0, M1 with alternating Address 1, 2; no double grant.
- Requester holds Req high during its Ack cycle: no second WrEN is issued for that request.
- RST pulled low while in WAIT_RD: all outputs go to 0 immediately; a late RdData_valid = 1 produces no Ack.
- With RF_ARB_TIMEOUT_EN and no RdData_valid: Rd_error and M0_Ack pulse 15 cycles after entering WAIT_RD; M0_RdData_valid stays 0.
